// File: rtl/icmp_echo_initiator.sv
// icmp_echo_initiator
//   Ping generator. On ping_start it builds an ICMP echo request (type 8),
//   streams it byte-wise to the IP transmit layer, then watches the ICMP
//   receive stream for the matching echo reply. The result, an error code
//   and the round-trip time in clock cycles are reported.
//
// Ports
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   ping_start                one-cycle request pulse (accepted in IDLE only)
//   ping_dst_ip/ping_dst_mac  target addresses, sampled with ping_start
//   tx_ready                  transmit layer can take a whole frame
//   icmp_tx_*                 request stream + ip_len/dst_ip/dst_mac sideband
//   icmp_rx_*                 ICMP receive stream (first byte = ICMP type)
//   ping_busy                 high outside IDLE
//   ping_done                 one-cycle result pulse
//   ping_ok/ping_err          last result (err: 0 ok, 1 timeout, 2 bad reply)
//   ping_rtt                  cycles from tx sop to reply eop
//   ping_seq                  sequence number of current/last ping
module icmp_echo_initiator #(
  parameter int unsigned PAYLOAD_LEN = 32,
  parameter logic [15:0] ICMP_ID     = 16'h4644,
  parameter logic [31:0] TIMEOUT_CYC = 32'd125000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ping_start,
  input  logic [31:0] ping_dst_ip,
  input  logic [47:0] ping_dst_mac,
  input  logic        tx_ready,
  output logic [15:0] icmp_tx_ip_len,
  output logic [31:0] icmp_tx_dst_ip,
  output logic [47:0] icmp_tx_dst_mac,
  output logic        icmp_tx_sop,
  output logic        icmp_tx_eop,
  output logic        icmp_tx_vld,
  output logic [7:0]  icmp_tx_dat,
  input  logic        icmp_rx_sop,
  input  logic        icmp_rx_eop,
  input  logic        icmp_rx_vld,
  input  logic [7:0]  icmp_rx_dat,
  output logic        ping_busy,
  output logic        ping_done,
  output logic        ping_ok,
  output logic [1:0]  ping_err,
  output logic [31:0] ping_rtt,
  output logic [15:0] ping_seq
);

  localparam int unsigned FRAME_LEN = PAYLOAD_LEN + 8;
  localparam logic [6:0]  LAST_IDX  = 7'(FRAME_LEN - 1);
  localparam logic [15:0] IP_LEN    = 16'(28 + PAYLOAD_LEN);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_TX    = 3'd1;
  localparam logic [2:0] S_SEND       = 3'd2;
  localparam logic [2:0] S_WAIT_REPLY = 3'd3;
  localparam logic [2:0] S_REPORT     = 3'd4;

  // Payload bytes are k[7:0], so their word sum is fixed at elaboration.
  function automatic logic [31:0] payload_sum();
    logic [31:0] s;
    s = '0;
    for (int unsigned j = 0; j < PAYLOAD_LEN / 2; j++)
      s = s + {16'h0000, 8'(2 * j), 8'(2 * j + 1)};
    return s;
  endfunction

  localparam logic [31:0] PAY_SUM = payload_sum();

  logic [2:0]  state;
  logic [15:0] csum_reg;
  logic [6:0]  tx_idx;
  logic [31:0] rtt_cnt;
  logic [31:0] to_cnt;

  // ---------------- checksum ----------------
  logic [31:0] csum_acc;
  logic [31:0] csum_f1;
  logic [15:0] csum_f2;
  logic [15:0] csum_calc;

  always_comb begin
    csum_acc  = 32'h0000_0800 + {16'h0000, ICMP_ID} + {16'h0000, ping_seq} + PAY_SUM;
    csum_f1   = {16'h0000, csum_acc[15:0]} + {16'h0000, csum_acc[31:16]};
    csum_f2   = csum_f1[15:0] + csum_f1[31:16];
    csum_calc = ~csum_f2;
  end

  // ---------------- tx byte generator ----------------
  // tx_dat is registered, so the byte for index tx_idx+1 is prepared here.
  logic [6:0] tx_nidx;
  logic [7:0] tx_pay;
  logic [7:0] tx_next_byte;

  assign tx_nidx = tx_idx + 7'd1;
  assign tx_pay  = {1'b0, tx_nidx} - 8'd8;

  always_comb begin
    case (tx_nidx)
      7'd0:    tx_next_byte = 8'h08;
      7'd1:    tx_next_byte = 8'h00;
      7'd2:    tx_next_byte = csum_reg[15:8];
      7'd3:    tx_next_byte = csum_reg[7:0];
      7'd4:    tx_next_byte = ICMP_ID[15:8];
      7'd5:    tx_next_byte = ICMP_ID[7:0];
      7'd6:    tx_next_byte = ping_seq[15:8];
      7'd7:    tx_next_byte = ping_seq[7:0];
      default: tx_next_byte = tx_pay;
    endcase
  end

  // ---------------- rx parser ----------------
  logic        rx_active;
  logic [6:0]  rx_idx;
  logic [15:0] rx_sum;
  logic        rx_miss;
  logic        rx_bad;

  logic        rx_take;
  logic [6:0]  cur_idx;
  logic [15:0] cur_sum;
  logic        cur_miss;
  logic        cur_bad;
  logic [7:0]  rx_pay_exp;
  logic        byte_miss;
  logic        byte_bad;
  logic [15:0] rx_word;
  logic [16:0] sum17;
  logic [15:0] sum_n;
  logic        miss_n;
  logic        bad_n;
  logic        rx_reply;
  logic        rx_good;
  logic        timeout_hit;

  // A sop always restarts the parser, even in the middle of a frame; bytes
  // with no preceding sop in WAIT_REPLY are skipped.
  assign rx_take    = (state == S_WAIT_REPLY) && icmp_rx_vld && (icmp_rx_sop || rx_active);
  assign cur_idx    = icmp_rx_sop ? 7'd0  : rx_idx;
  assign cur_sum    = icmp_rx_sop ? 16'd0 : rx_sum;
  assign cur_miss   = icmp_rx_sop ? 1'b0  : rx_miss;
  assign cur_bad    = icmp_rx_sop ? 1'b0  : rx_bad;
  assign rx_pay_exp = {1'b0, cur_idx} - 8'd8;

  always_comb begin
    byte_miss = 1'b0;
    byte_bad  = 1'b0;
    case (cur_idx)
      7'd0, 7'd1: byte_miss = (icmp_rx_dat != 8'h00);
      7'd2, 7'd3: byte_miss = 1'b0;
      7'd4:       byte_miss = (icmp_rx_dat != ICMP_ID[15:8]);
      7'd5:       byte_miss = (icmp_rx_dat != ICMP_ID[7:0]);
      7'd6:       byte_miss = (icmp_rx_dat != ping_seq[15:8]);
      7'd7:       byte_miss = (icmp_rx_dat != ping_seq[7:0]);
      default:    byte_bad  = (cur_idx <= LAST_IDX) && (icmp_rx_dat != rx_pay_exp);
    endcase
  end

  always_comb begin
    rx_word = cur_idx[0] ? {8'h00, icmp_rx_dat} : {icmp_rx_dat, 8'h00};
    sum17   = {1'b0, cur_sum} + {1'b0, rx_word};
    sum_n   = sum17[15:0] + {15'd0, sum17[16]};
    miss_n  = cur_miss | byte_miss;
    bad_n   = cur_bad | byte_bad;
  end

  // A frame counts as our reply only once all eight header bytes matched;
  // shorter or mismatching frames are treated as foreign and ignored.
  assign rx_reply    = rx_take && icmp_rx_eop && (cur_idx >= 7'd7) && !miss_n;
  assign rx_good     = rx_reply && !bad_n && (cur_idx == LAST_IDX) && (sum_n == 16'hFFFF);
  assign timeout_hit = (to_cnt == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_active <= 1'b0;
      rx_idx    <= '0;
      rx_sum    <= '0;
      rx_miss   <= 1'b0;
      rx_bad    <= 1'b0;
    end else if (rx_take) begin
      rx_active <= !icmp_rx_eop;
      rx_idx    <= (cur_idx == 7'd127) ? cur_idx : cur_idx + 7'd1;
      rx_sum    <= sum_n;
      rx_miss   <= miss_n;
      rx_bad    <= bad_n;
    end else if (state != S_WAIT_REPLY) begin
      rx_active <= 1'b0;
    end
  end

  // ---------------- main FSM ----------------
  assign ping_busy = (state != S_IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= S_IDLE;
      csum_reg        <= '0;
      tx_idx          <= '0;
      rtt_cnt         <= '0;
      to_cnt          <= '0;
      icmp_tx_ip_len  <= '0;
      icmp_tx_dst_ip  <= '0;
      icmp_tx_dst_mac <= '0;
      icmp_tx_sop     <= 1'b0;
      icmp_tx_eop     <= 1'b0;
      icmp_tx_vld     <= 1'b0;
      icmp_tx_dat     <= '0;
      ping_done       <= 1'b0;
      ping_ok         <= 1'b0;
      ping_err        <= '0;
      ping_rtt        <= '0;
      ping_seq        <= '0;
    end else begin
      ping_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ping_start) begin
            icmp_tx_dst_ip  <= ping_dst_ip;
            icmp_tx_dst_mac <= ping_dst_mac;
            icmp_tx_ip_len  <= IP_LEN;
            ping_seq        <= ping_seq + 16'd1;
            state           <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          csum_reg <= csum_calc;
          if (tx_ready) begin
            tx_idx      <= '0;
            icmp_tx_vld <= 1'b1;
            icmp_tx_sop <= 1'b1;
            icmp_tx_eop <= 1'b0;
            icmp_tx_dat <= 8'h08;
            rtt_cnt     <= '0;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (rtt_cnt != '1) rtt_cnt <= rtt_cnt + 32'd1;
          if (tx_idx == LAST_IDX) begin
            icmp_tx_vld <= 1'b0;
            icmp_tx_sop <= 1'b0;
            icmp_tx_eop <= 1'b0;
            icmp_tx_dat <= '0;
            to_cnt      <= '0;
            state       <= S_WAIT_REPLY;
          end else begin
            tx_idx      <= tx_nidx;
            icmp_tx_dat <= tx_next_byte;
            icmp_tx_sop <= 1'b0;
            icmp_tx_eop <= (tx_nidx == LAST_IDX);
          end
        end
        S_WAIT_REPLY: begin
          if (rtt_cnt != '1) rtt_cnt <= rtt_cnt + 32'd1;
          to_cnt <= to_cnt + 32'd1;
          // Reply evaluation takes priority so an eop on the expiry cycle wins.
          if (rx_reply) begin
            ping_done <= 1'b1;
            ping_ok   <= rx_good;
            ping_err  <= rx_good ? 2'd0 : 2'd2;
            ping_rtt  <= rtt_cnt;
            state     <= S_REPORT;
          end else if (timeout_hit) begin
            ping_done <= 1'b1;
            ping_ok   <= 1'b0;
            ping_err  <= 2'd1;
            ping_rtt  <= rtt_cnt;
            state     <= S_REPORT;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
